// File: rtl/vga_scan_controller.sv
// 800x600@72 raster sequencer with 2x pixel/line doubling from a 400x300 image memory.
// Optional frame counter output enabled by VGA_SCAN_FRAME_CNT_EN.
module vga_scan_controller #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int IMG_W    = 400,
  parameter int IMG_H    = 300,
  parameter int MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [10:0] count_rgb,
  output logic [9:0]  reset_count_rgb,
  output logic        rd_en,
  output logic [16:0] rd_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        busy
`ifdef VGA_SCAN_FRAME_CNT_EN
  , output logic [7:0] frame_cnt
`endif
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state, state_nxt;

  logic [10:0] h;
  logic [9:0]  v;
  logic [16:0] row_base, addr_hold;
  logic        h_last, v_last, frame_end, running;
  logic        active_raw, hsync_raw, vsync_raw;
  logic [MEM_LAT-1:0][2:0] dly_pipe;

  assign h_last    = (h == 11'(H_TOT - 1));
  assign v_last    = (v == 10'(V_TOT - 1));
  assign frame_end = h_last && v_last;
  assign running   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // A stop only lands in IDLE on the last pixel of the frame, so sync is never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enable) state_nxt = RUN;
      RUN:      if (!enable) state_nxt = STOPPING;
      STOPPING: if (enable) state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (!running) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 10'd1;
    end else begin
      h <= h + 11'd1;
    end

  assign active_raw = (h < 11'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
  assign hsync_raw  = (h >= 11'(H_ACTIVE + H_FP)) && (h < 11'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_raw  = (v >= 10'(V_ACTIVE + V_FP)) && (v < 10'(V_ACTIVE + V_FP + V_SYNC));

  assign rd_en           = active_raw && running;
  assign frame_start     = running && (h == '0) && (v == '0);
  assign busy            = running;
  assign count_rgb       = h;
  assign reset_count_rgb = v;

  // Row base steps after each odd line so line pairs 2k/2k+1 read the same image row.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      row_base <= '0;
    else if (running) begin
      if (frame_end)
        row_base <= '0;
      else if (h_last && v < 10'(2 * IMG_H - 1) && v[0])
        row_base <= row_base + 17'(IMG_W);
    end

  assign rd_addr = active_raw ? row_base + 17'(h[10:1]) : addr_hold;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr_hold <= '0;
    else        addr_hold <= rd_addr;

  // Sync and enable ride alongside the memory read so they line up with returned data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      dly_pipe <= '0;
    else begin
      dly_pipe[0] <= {hsync_raw, vsync_raw, rd_en};
      for (int i = 1; i < MEM_LAT; i++) dly_pipe[i] <= dly_pipe[i-1];
    end

  assign {hsync, vsync, de} = dly_pipe[MEM_LAT-1];

`ifdef VGA_SCAN_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)           frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 8'd1;
`endif

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench: a shrunken raster (24x14 total, MEM_LAT=2) for whole-frame behaviour,
// plus a default 800x600 instance for real line timing on the first line.
module tb_vga_scan_controller;
  logic clk = 1'b0;
  logic rst_n, enable;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Small raster: H 16/2/3/3 -> 24, hsync h 18..20; V 8/2/2/2 -> 14, vsync v 10..11.
  logic [10:0] s_count_rgb;
  logic [9:0]  s_reset_count_rgb;
  logic        s_rd_en, s_hsync, s_vsync, s_de, s_frame_start, s_busy;
  logic [16:0] s_rd_addr;
`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [7:0]  s_frame_cnt, d_frame_cnt;
`endif

  logic [10:0] d_count_rgb;
  logic [9:0]  d_reset_count_rgb;
  logic        d_rd_en, d_hsync, d_vsync, d_de, d_frame_start, d_busy;
  logic [16:0] d_rd_addr;

  vga_scan_controller #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(8), .IMG_H(4), .MEM_LAT(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .count_rgb(s_count_rgb), .reset_count_rgb(s_reset_count_rgb),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .hsync(s_hsync), .vsync(s_vsync),
    .de(s_de), .frame_start(s_frame_start), .busy(s_busy)
`ifdef VGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(s_frame_cnt)
`endif
  );

  vga_scan_controller dut_d (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .count_rgb(d_count_rgb), .reset_count_rgb(d_reset_count_rgb),
    .rd_en(d_rd_en), .rd_addr(d_rd_addr), .hsync(d_hsync), .vsync(d_vsync),
    .de(d_de), .frame_start(d_frame_start), .busy(d_busy)
`ifdef VGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(d_frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for the small raster's frame_start; lands on that sample point.
  task automatic sync_frame();
    int n = 0;
    while (s_frame_start !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    chk("sync_frame_timeout", 32'(n < 400), 1);
  endtask

  initial begin
    int de_cnt, vs_cnt, fs_cnt;
    rst_n = 1'b0;
    enable = 1'b0;
    tick(2);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_h", 32'(s_count_rgb), 0);
    chk("rst_rd_en", 32'(s_rd_en), 0);
    chk("rst_sync_de", 32'({s_hsync, s_vsync, s_de, s_frame_start}), 0);
    chk("rst_d_busy", 32'(d_busy), 0);

    rst_n = 1'b1;
    tick(1);
    chk("idle_busy", 32'(s_busy), 0);
    chk("idle_fs", 32'(s_frame_start), 0);

    enable = 1'b1;
    tick(1); // first RUN cycle, h=0 v=0
    chk("run_fs", 32'(s_frame_start), 1);
    chk("run_d_fs", 32'(d_frame_start), 1);
    chk("run_busy", 32'(s_busy), 1);
    chk("h0_addr", 32'(s_rd_addr), 0);
    chk("h0_rd_en", 32'(s_rd_en), 1);
    chk("h0_de", 32'(s_de), 0);
    tick(1);
    chk("h1_addr", 32'(s_rd_addr), 0);
    chk("h1_de_lat2", 32'(s_de), 0);
    chk("h1_fs", 32'(s_frame_start), 0);
    chk("d_h1_de_lat1", 32'(d_de), 1);
    tick(1);
    chk("h2_addr", 32'(s_rd_addr), 1);
    chk("h2_de_lat2", 32'(s_de), 1);
    tick(1);
    chk("h3_addr", 32'(s_rd_addr), 1);
    tick(12);
    chk("h15_addr", 32'(s_rd_addr), 7);
    tick(1);
    chk("h16_rd_en", 32'(s_rd_en), 0);
    chk("h16_addr_hold", 32'(s_rd_addr), 7);
    chk("h16_de", 32'(s_de), 1);
    tick(1);
    chk("h17_de", 32'(s_de), 1);
    tick(1);
    chk("h18_de", 32'(s_de), 0);
    tick(1);
    chk("h19_hsync", 32'(s_hsync), 0);
    tick(1);
    chk("h20_hsync", 32'(s_hsync), 1);
    tick(2);
    chk("h22_hsync", 32'(s_hsync), 1);
    tick(1);
    chk("h23_hsync", 32'(s_hsync), 0);
    tick(1);
    chk("v1_h", 32'(s_count_rgb), 0);
    chk("v1_v", 32'(s_reset_count_rgb), 1);
    chk("v1_addr", 32'(s_rd_addr), 0);
    tick(24);
    chk("v2_addr", 32'(s_rd_addr), 8);

    // Default instance is at h=48 on line 0.
    chk("d_h48", 32'(d_count_rgb), 48);
    tick(751);
    chk("d_h799_addr", 32'(d_rd_addr), 399);
    chk("d_h799_rd_en", 32'(d_rd_en), 1);
    tick(1);
    chk("d_h800_de", 32'(d_de), 1);
    tick(1);
    chk("d_h801_de", 32'(d_de), 0);
    tick(55);
    chk("d_h856_hsync", 32'(d_hsync), 0);
    tick(1);
    chk("d_h857_hsync", 32'(d_hsync), 1);
    tick(119);
    chk("d_h976_hsync", 32'(d_hsync), 1);
    chk("d_vsync_line0", 32'(d_vsync), 0);
    tick(1);
    chk("d_h977_hsync", 32'(d_hsync), 0);
    tick(62);
    chk("d_h1039", 32'(d_count_rgb), 1039);
    tick(1);
    chk("d_wrap_h", 32'(d_count_rgb), 0);
    chk("d_wrap_v", 32'(d_reset_count_rgb), 1);

    // Whole small frame: addressing, vsync placement and de/vsync/frame_start totals.
    sync_frame();
    tick(7 * 24 + 15);
    chk("last_addr", 32'(s_rd_addr), 31);
    tick(58);
    chk("v10h1_vsync", 32'(s_vsync), 0);
    tick(1);
    chk("v10h2_vsync", 32'(s_vsync), 1);
    sync_frame();
    de_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 336; i++) begin
      de_cnt += int'(s_de);
      vs_cnt += int'(s_vsync);
      fs_cnt += int'(s_frame_start);
      tick(1);
    end
    chk("frame_de_cnt", 32'(de_cnt), 128);
    chk("frame_vsync_cnt", 32'(vs_cnt), 48);
    chk("frame_fs_cnt", 32'(fs_cnt), 1);
    chk("frame_period_fs", 32'(s_frame_start), 1);

    // Stop mid-frame: the frame runs out, then everything parks at zero.
    tick(96);
    enable = 1'b0;
    tick(1);
    chk("stop_busy", 32'(s_busy), 1);
    tick(238);
    chk("stop_end_busy", 32'(s_busy), 1);
    chk("stop_end_h", 32'(s_count_rgb), 23);
    chk("stop_end_v", 32'(s_reset_count_rgb), 13);
    tick(1);
    chk("stopped_busy", 32'(s_busy), 0);
    chk("stopped_hv", 32'({s_count_rgb, s_reset_count_rgb}), 0);
    chk("stopped_fs", 32'(s_frame_start), 0);
    fs_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      fs_cnt += int'(s_frame_start);
      tick(1);
    end
    chk("idle_no_fs", 32'(fs_cnt), 0);
    chk("idle_h", 32'(s_count_rgb), 0);

    // Asynchronous reset mid-line.
    enable = 1'b1;
    sync_frame();
    tick(2 * 24 + 5);
    chk("pre_rst_addr", 32'(s_rd_addr), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(s_busy), 0);
    chk("async_hv", 32'({s_count_rgb, s_reset_count_rgb}), 0);
    chk("async_addr", 32'(s_rd_addr), 0);
    chk("async_outs", 32'({s_rd_en, s_hsync, s_vsync, s_de, s_frame_start}), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("restart_fs", 32'(s_frame_start), 1);
    chk("restart_addr", 32'(s_rd_addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
